// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, reads instruction memory combinationally
// and queues {instr, pc} pairs in a small prefetch FIFO toward decode.
module instruction_fetch #(
  parameter int unsigned        WIDTH1   = 32,
  parameter logic [WIDTH1-1:0]  RESET_PC = '0,
  parameter int unsigned        DEPTH    = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [WIDTH1-1:0]          imem_addr,
  input  logic [WIDTH1-1:0]          imem_rdata,
  input  logic                       fetch_en,
  input  logic                       redirect_valid,
  input  logic [WIDTH1-1:0]          redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH1-1:0]          out_instr,
  output logic [WIDTH1-1:0]          out_pc,
  output logic [$clog2(DEPTH):0]     buf_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH1-1:0] pc_r;
  logic [WIDTH1-1:0] instr_mem_r [DEPTH];
  logic [WIDTH1-1:0] pc_mem_r    [DEPTH];
  logic [PW-1:0]     rd_ptr_r;
  logic [PW-1:0]     wr_ptr_r;
  logic [CW-1:0]     count_r;
  logic              pop_s;
  logic              push_s;
  logic              not_empty_s;
  logic [WIDTH1-1:0] redirect_aligned_s;

  // Handshake qualifiers; a redirect suppresses both push and pop.
  always_comb begin
    not_empty_s        = (count_r != {CW{1'b0}});
    pop_s              = not_empty_s & out_ready & ~redirect_valid;
    push_s             = fetch_en & ~redirect_valid &
                         ((count_r < CW'(DEPTH)) | pop_s);
    redirect_aligned_s = redirect_pc & {{(WIDTH1-2){1'b1}}, 2'b00};
  end

  // PC, FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r     <= RESET_PC;
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < int'(DEPTH); i++) begin
        instr_mem_r[i] <= {WIDTH1{1'b0}};
        pc_mem_r[i]    <= {WIDTH1{1'b0}};
      end
    end else if (redirect_valid) begin
      pc_r     <= redirect_aligned_s;
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        instr_mem_r[wr_ptr_r] <= imem_rdata;
        pc_mem_r[wr_ptr_r]    <= pc_r;
        wr_ptr_r              <= wr_ptr_r + PW'(1'b1);
        pc_r                  <= pc_r + WIDTH1'(32'd4);
      end else begin
        pc_r <= pc_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r <= count_r + CW'(push_s) - CW'(pop_s);
    end
  end

  // Head of the FIFO is presented directly from storage.
  always_comb begin
    imem_addr = pc_r;
    out_valid = not_empty_s & ~redirect_valid;
    out_instr = instr_mem_r[rd_ptr_r];
    out_pc    = pc_mem_r[rd_ptr_r];
    buf_count = count_r;
  end

endmodule
